// File: rtl/sr_cmd_sched.sv
// sr_cmd_sched: round-robin scheduler issuing one-cycle S/R pulses to a shared SR flip-flop bank (readback check under SR_SCHED_VERIFY_EN).
// Latency: gnt and the S/R pulse come one cycle after req is sampled; ack comes with the pulse, or one cycle later with readback.
// Backpressure: req is a level held until ack; one command in flight, losing requesters wait in place.
module sr_cmd_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    op_i,
  input  logic [NREQ*IW-1:0] idx_i,
  input  logic [WIDTH-1:0]   q_i,
  output logic [WIDTH-1:0]   s_o,
  output logic [WIDTH-1:0]   r_o,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    ack_o,
  output logic               err_o,
  output logic               busy_o
);

`ifdef SR_SCHED_VERIFY_EN
  localparam logic VERIFY = 1'b1;
`else
  localparam logic VERIFY = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              op_q, op_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              oor_q, oor_d;

  logic              found;
  logic [PW-1:0]     win;
  logic [PW:0]       sum;
  logic [NREQ-1:0]   gnt_sel;
  logic              op_sel;
  logic [IW-1:0]     idx_sel;
  logic              oor_sel;
  logic [WIDTH-1:0]  dec;
  logic              q_bit;

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (!found && req_i[sum[PW-1:0]]) begin
        found = 1'b1;
        win   = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    gnt_sel = '0;
    op_sel  = 1'b0;
    idx_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == PW'(k)) begin
        gnt_sel[k] = found;
        op_sel     = op_i[k];
        idx_sel    = idx_i[k*IW +: IW];
      end
    end
    oor_sel = ({1'b0, idx_sel} >= (IW+1)'(WIDTH));
    // An out-of-range index matches no bit, so no pulse is driven for it.
    dec = '0;
    for (int i = 0; i < WIDTH; i++) dec[i] = (idx_sel == IW'(i));
  end

  always_comb begin
    q_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx_q == IW'(i)) q_bit = q_i[i];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    s_d     = '0;
    r_d     = '0;
    op_d    = op_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          ptr_d   = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
          gnt_d   = gnt_sel;
          op_d    = op_sel;
          idx_d   = idx_sel;
          oor_d   = oor_sel;
          s_d     = op_sel ? dec : '0;
          r_d     = op_sel ? '0 : dec;
          ack_d   = VERIFY ? '0 : gnt_sel;
        end
      end
      ISSUE: begin
`ifdef SR_SCHED_VERIFY_EN
        state_d = CHECK;
        ack_d   = gnt_q;
`else
        state_d = IDLE;
        gnt_d   = '0;
`endif
      end
      CHECK: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      s_q     <= s_d;
      r_q     <= r_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
    end
  end

  assign s_o    = s_q;
  assign r_o    = r_q;
  assign gnt_o  = gnt_q;
  assign ack_o  = ack_q;
  assign busy_o = (state_q != IDLE);
  // Readback is compared in the ack cycle itself, after the bank has captured the pulse.
  assign err_o  = (|ack_q) & (oor_q | (VERIFY & (q_bit != op_q)));

endmodule

// File: tb/tb_sr_cmd_sched.sv
// Bench for sr_cmd_sched (NREQ=4, WIDTH=6) with an SR bank model; stimulus queues expected
// grants, pulses and acks with their cycle numbers, a negedge monitor pops and compares them.
module tb_sr_cmd_sched;
`ifdef SR_SCHED_VERIFY_EN
  localparam int   L   = 2;
  localparam logic VER = 1'b1;
`else
  localparam int   L   = 1;
  localparam logic VER = 1'b0;
`endif
  localparam int P = L + 1;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    int         cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i, op_i;
  logic [11:0] idx_i;
  logic [5:0]  q_i, s_o, r_o;
  logic [3:0]  gnt_o, ack_o;
  logic        err_o, busy_o;

  logic [5:0]  bank, bank_val, stuck;
  logic        bank_load;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          zero_cyc, tmo;
  logic        final_req, done = 1'b0;
  logic [3:0]  prev_gnt = '0;
  ev_t         gq[$], pq[$], aq[$];

  sr_cmd_sched #(.NREQ(4), .WIDTH(6)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .op_i(op_i), .idx_i(idx_i), .q_i(q_i),
    .s_o(s_o), .r_o(r_o), .gnt_o(gnt_o), .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bank_load) bank <= bank_val;
    else           bank <= (bank | s_o) & ~r_o;
  end
  assign q_i = bank & ~stuck;

  task automatic step();
    @(posedge clk);
    #1;
    req_i = req_i & ~ack_o;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while ((req_i != 0 || busy_o) && n < budget);
    if (req_i != 0 || busy_o) tmo++;
  endtask

  task automatic expect_cmd(input int who, input int n, input logic [5:0] s,
                            input logic [5:0] r, input logic e);
    gq.push_back('{6'(1 << who), 6'd0, n + 1});
    if ((s | r) != 0) pq.push_back('{s, r, n + 1});
    aq.push_back('{6'(1 << who), 6'(e), n + L});
  endtask

  task automatic cmd(input int who, input logic o, input int ix, input logic [5:0] s,
                     input logic [5:0] r, input logic e);
    req_i[who] = 1'b1;
    op_i[who] = o;
    idx_i[who*3 +: 3] = 3'(ix);
    expect_cmd(who, cyc, s, r, e);
    wait_idle(20);
  endtask

  always @(negedge clk) begin
    ev_t e;
    total++;
    if ((s_o & r_o) != 0 || $countones(s_o | r_o) > 1) begin
      bad++;
      $display("FAIL sr_excl cyc=%0d: s=%h r=%h, want disjoint and at most one bit", cyc, s_o, r_o);
    end
    total++;
    if ($countones(ack_o) > 1 || (ack_o & ~gnt_o) != 0 || (err_o && ack_o == 0)) begin
      bad++;
      $display("FAIL ack_inv cyc=%0d: ack=%b gnt=%b err=%b", cyc, ack_o, gnt_o, err_o);
    end
    if (cyc == zero_cyc) begin
      total++;
      if ({s_o, r_o, gnt_o, ack_o, err_o, busy_o} != '0) begin
        bad++;
        $display("FAIL reset_zero cyc=%0d: s=%h r=%h gnt=%b ack=%b err=%b busy=%b, want all 0",
                 cyc, s_o, r_o, gnt_o, ack_o, err_o, busy_o);
      end
    end
    if (gnt_o != 0 && prev_gnt == 0) begin
      total++;
      if (gq.size() == 0) begin
        bad++;
        $display("FAIL grant cyc=%0d: unexpected gnt=%b", cyc, gnt_o);
      end else begin
        e = gq.pop_front();
        if (gnt_o != e.a[3:0] || cyc != e.cyc || !busy_o) begin
          bad++;
          $display("FAIL grant: got gnt=%b cyc=%0d busy=%b, want gnt=%b cyc=%0d busy=1",
                   gnt_o, cyc, busy_o, e.a[3:0], e.cyc);
        end
      end
    end
    if ((s_o | r_o) != 0) begin
      total++;
      if (pq.size() == 0) begin
        bad++;
        $display("FAIL pulse cyc=%0d: unexpected s=%h r=%h", cyc, s_o, r_o);
      end else begin
        e = pq.pop_front();
        if (s_o != e.a || r_o != e.b || cyc != e.cyc) begin
          bad++;
          $display("FAIL pulse: got s=%h r=%h cyc=%0d, want s=%h r=%h cyc=%0d",
                   s_o, r_o, cyc, e.a, e.b, e.cyc);
        end
      end
    end
    if (ack_o != 0) begin
      total++;
      if (aq.size() == 0) begin
        bad++;
        $display("FAIL ack cyc=%0d: unexpected ack=%b", cyc, ack_o);
      end else begin
        e = aq.pop_front();
        if (ack_o != e.a[3:0] || err_o != e.b[0] || cyc != e.cyc) begin
          bad++;
          $display("FAIL ack: got ack=%b err=%b cyc=%0d, want ack=%b err=%b cyc=%0d",
                   ack_o, err_o, cyc, e.a[3:0], e.b[0], e.cyc);
        end
      end
    end
    prev_gnt = gnt_o;
    if (final_req && !done) begin
      total++;
      if (gq.size() + pq.size() + aq.size() != 0 || tmo != 0 || q_i != 6'h21) begin
        bad++;
        $display("FAIL final: left g=%0d p=%0d a=%0d timeouts=%0d q=%h, want 0 0 0 0 q=21",
                 gq.size(), pq.size(), aq.size(), tmo, q_i);
      end
      done = 1'b1;
    end
  end

  initial begin
    int c;
    rst_i = 1'b1; req_i = '0; op_i = '0; idx_i = '0;
    bank_load = 1'b1; bank_val = '0; stuck = '0;
    zero_cyc = -1; tmo = 0; final_req = 1'b0;
    step();
    step();
    zero_cyc = cyc;
    rst_i = 1'b0;
    bank_val = 6'h3F;
    step();
    bank_load = 1'b0;

    // All four at once from pointer 0: grants 0..3 spaced by the command period.
    req_i = 4'b1111;
    op_i  = 4'b0101;
    idx_i = {3'd3, 3'd2, 3'd1, 3'd0};
    c = cyc;
    expect_cmd(0, c,         6'h01, 6'h00, 1'b0);
    expect_cmd(1, c + P,     6'h00, 6'h02, 1'b0);
    expect_cmd(2, c + 2 * P, 6'h04, 6'h00, 1'b0);
    expect_cmd(3, c + 3 * P, 6'h00, 6'h08, 1'b0);
    wait_idle(40);

    bank_load = 1'b1;
    bank_val  = 6'h00;
    step();
    bank_load = 1'b0;
    cmd(0, 1'b1, 3, 6'h08, 6'h00, 1'b0);

    stuck = 6'h20;
    cmd(1, 1'b1, 5, 6'h20, 6'h00, VER);
    stuck = 6'h00;

    cmd(2, 1'b1, 7, 6'h00, 6'h00, 1'b1);
    cmd(3, 1'b0, 6, 6'h00, 6'h00, 1'b1);

    // Reset lands in the ISSUE cycle: the pulse stands, the ack (if not yet out) is dropped.
    req_i[1] = 1'b1;
    op_i[1] = 1'b0;
    idx_i[5:3] = 3'd3;
    c = cyc;
    gq.push_back('{6'b000010, 6'd0, c + 1});
    pq.push_back('{6'h00, 6'h08, c + 1});
    if (!VER) aq.push_back('{6'b000010, 6'd0, c + 1});
    step();
    rst_i = 1'b1;
    req_i = 4'b0100;
    op_i[2] = 1'b1;
    idx_i[8:6] = 3'd0;
    zero_cyc = c + 2;
    step();
    rst_i = 1'b0;
    expect_cmd(2, cyc, 6'h01, 6'h00, 1'b0);
    wait_idle(20);

    step();
    final_req = 1'b1;
    for (int n = 0; n < 10 && !done; n++) step();
    if (!done) begin
      $display("FAIL final_check: monitor did not complete");
      $fatal(1, "final check not reached");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sr_cmd_sched.md
# sr_cmd_sched

Round-robin command scheduler that shares one bank of `WIDTH` set/reset flip-flops among `NREQ` requesters. Each requester asks to set or clear one bit. The scheduler grants one command at a time and drives a single one-cycle S or R pulse into the bank. It can optionally read the bank back to confirm the write. By construction it never drives S and R high together on any bit, so the bank's invalid state cannot be reached.

## Interface
- `NREQ`, default 4: number of requesters, range 2–8.
- `WIDTH`, default 8: number of flip-flops in the bank. `IW = max(1, $clog2(WIDTH))` is derived from it.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NREQ: per-requester command request. It is a level that the requester holds until `ack`.
- `op` in NREQ: per-requester operation. 1 means set, 0 means clear.
- `idx` in NREQ*IW: per-requester target bit index. Requester i uses slice `[i*IW +: IW]`.
- `q` in WIDTH: current outputs of the flip-flop bank.
- `S` out WIDTH: set pulses to the bank, registered.
- `R` out WIDTH: reset pulses to the bank, registered.
- `gnt` out NREQ: one-hot marker for the requester whose command is in flight, registered.
- `ack` out NREQ: one-cycle completion pulse to the granted requester, registered.
- `err` out 1: qualifies `ack`. When high, the command failed.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset values: `S`, `R`, `gnt`, `ack` are all zero; `err` and `busy` are 0; the state is IDLE; the round-robin pointer is 0.
- The state machine has three states: IDLE, ISSUE and CHECK.
- **IDLE**
  - With no `req` bit high, the block stays in IDLE.
  - Otherwise it selects the first high `req` at or after the pointer, wrapping modulo `NREQ`.
  - It latches the winner's `op` and `idx`, sets `gnt` one-hot, and moves to ISSUE.
  - The pointer becomes winner+1 modulo `NREQ`.
- **ISSUE**
  - Exactly one bit of `S` (when `op`=1) or of `R` (when `op`=0) is high, at the latched `idx`.
  - Exit:
    - With `SR_SCHED_VERIFY_EN` defined, the next state is CHECK.
    - Without it, the block pulses `ack`/`err` and returns to IDLE.
- **CHECK** (only with `SR_SCHED_VERIFY_EN` defined)
  - `S` and `R` are zero.
  - The block pulses `ack` for the granted requester.
  - `err` = (`q[idx]` != `op`).
  - The next state is IDLE.
- **Out-of-range index** (`idx` >= `WIDTH`, possible when `WIDTH` is not a power of two)
  - No S/R pulse is driven.
  - The command still completes at the normal time, with `err`=1.
- **Operation is fixed at grant**
  - Changes to the granted requester's `req`, `op` or `idx` after the grant are ignored.
  - A `req` that drops before `ack` still receives `ack`.
  - Requests from other requesters during ISSUE or CHECK wait; none is lost while `req` stays high.
- **Clearing `gnt`:** `gnt` is cleared in the cycle after `ack`.
- **Invariants, checked every cycle**
  - `S & R` == 0.
  - At most one bit of `S|R` is high.
  - `ack` is one-hot or zero, and is high only at the position of `gnt`.
  - `err` is high only when `ack` is high.

## Timing
- Request sampled in IDLE at cycle N:
  - `gnt` and `busy` go high in cycle N+1, and the S/R pulse occurs in cycle N+1 only.
  - The bank captures the pulse at the edge that ends N+1.
- With `SR_SCHED_VERIFY_EN` defined:
  - `ack` is high in N+2, and `q` is checked in that same cycle.
  - The block is back in IDLE in N+3, so the throughput is one command per 3 cycles.
- Without `SR_SCHED_VERIFY_EN`:
  - `ack` is high in N+1, together with the pulse.
  - The block is back in IDLE in N+2, so the throughput is one command per 2 cycles.
- **Requester obligation after `ack`:** the requester drops `req` by the edge that ends the `ack` cycle. If `req` is still high in the following IDLE cycle, it is treated as a new command.
- **Back-to-back requests:** with all requesters continuously requesting, grants rotate 0,1,…,NREQ-1,0 with no idle gap beyond the IDLE cycle.
- **Reset mid-operation:**
  - All outputs are zero in the cycle after `rst` is sampled.
  - Any in-flight command is dropped without `ack`.
  - An S/R pulse that was already driven is not retracted.

## Configuration
- Macro: `SR_SCHED_VERIFY_EN`.
- Defined:
  - The CHECK state is present.
  - `ack` is delayed one cycle, and `err` reports a readback mismatch or an out-of-range index.
- Undefined:
  - The CHECK state and the `q` comparison are removed; `q` is unused.
  - `ack` is issued in ISSUE, and `err` is high only for an out-of-range index.

## Test plan
- **Single set, verify on:** reset, then `req`=0001, `op[0]`=1, `idx0`=3, bank model connected.
  - `S`=0x08 for one cycle.
  - `ack`=0001 with `err`=0, 2 cycles after the sample; `q[3]`=1.
- **All requesters, round-robin:** `req`=1111, `op`=0101, `idx`=0,1,2,3, each requester dropping `req` after its `ack`.
  - Grant order is 0,1,2,3.
  - Final `q` = 0b0101 on bits 3:0, starting from all-ones.
  - `S&R`==0 on every cycle.
- **Readback fault, verify on:** bank model with bit 5 stuck at 0; set `idx`=5.
  - `S`=0x20.
  - `ack` with `err`=1.
- **Out-of-range index:** `WIDTH`=6, `idx`=7.
  - No S/R pulse.
  - `ack` with `err`=1 at normal latency.
- **Reset mid-command:** assert `rst` in the ISSUE cycle.
  - All outputs are zero next cycle and no `ack` is issued.
  - With `req`=0100 held after reset, the next grant goes to requester 2 (pointer back at 0).
- **Verify off:** the single-set scenario gives `ack` in the same cycle as `S`=0x08, and the next grant comes 2 cycles after the previous one.
